pl_stage_elastic: RTL and testbench
===================================

Name: pl_stage_elastic

Overview:
Generic, parametrised pipeline stage register. It replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block that carries a control field and a data field. It uses a valid/ready elastic handshake with a 2-entry skid buffer, so upstream stalls no longer need global WEN fan-out. Flush clears only control state (bubble insertion); data payload is don't-care while invalid.

Parameters:
CTRL_W, 16, width of control field (RegWrite, MemRead, MemWrite, Branch, Jump, halt, ...)
DATA_W, 128, width of data payload (rdat1, rdat2, immediates, register indices, pcn, ...)
CTRL_RST, '0, control value presented when stage is empty/flushed (a NOP bubble)
CNT_W, 16, width of perf counters (used only with optional feature)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; kills all held entries
in_valid  in  1  upstream holds a valid instruction
in_ready  out  1  stage can accept; registered
in_ctrl  in  CTRL_W  upstream control field
in_data  in  DATA_W  upstream payload
out_valid  out  1  stage presents a valid instruction
out_ready  in  1  downstream accepts this cycle
out_ctrl  out  CTRL_W  control field; CTRL_RST when out_valid=0
out_data  out  DATA_W  payload; holds last value when invalid
occupancy  out  2  entries held (0..2)

Behaviour:
- Reset (async, nRST=0): state EMPTY, in_ready=1, out_valid=0, out_ctrl=CTRL_RST, out_data=0, occupancy=0, skid cleared.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready. Both are evaluated on the same edge.
- Latency: an accepted entry appears on out_* the next cycle. Order is strict FIFO; no entry is dropped or duplicated absent flush.
- in_ready is a flop. It equals 1 in EMPTY/HALF and 0 in FULL. It never combinationally depends on out_ready.
- States:
  - EMPTY: Accept -> HALF (main <= in).
  - HALF: Accept & Emit -> HALF (main <= in). Accept & !Emit -> FULL (skid <= in). !Accept & Emit -> EMPTY. Neither -> HALF.
  - FULL: Emit -> HALF (main <= skid). No accept possible.
- flush has priority over everything, including a same-cycle Accept (the input is discarded). Next cycle: state EMPTY, out_valid=0, out_ctrl=CTRL_RST, in_ready=1. Data registers are not cleared.
- flush and nRST during FULL: both entries are lost. No partial state survives.
- out_ctrl is muxed to CTRL_RST whenever out_valid=0, so downstream never sees stale writes.
- in_ctrl/in_data are sampled only on Accept. Values while in_valid=0 are ignored.
- occupancy = 0/1/2 for EMPTY/HALF/FULL. It updates on the same edge as the state.

Optional Feature:
PL_STAGE_PERF_EN:
- Defined: adds outputs stall_cycles[CNT_W] (increments each cycle out_valid & !out_ready) and flush_count[CNT_W] (increments each cycle flush=1).
  - Both counters saturate at all-ones.
  - Both are reset to 0 by nRST only; flush does not clear them.
- Undefined: both ports and all counter logic are absent. Handshake behaviour is identical.

Decomposition:
- Shared package pl_stage_pkg: typedef enum logic [1:0] {PS_EMPTY, PS_HALF, PS_FULL} pl_state_t, and the default CTRL_RST constant.
- Optional sub-module pl_stage_perf holds the saturating counters. It is instantiated only under PL_STAGE_PERF_EN.
- Stage-specific struct packing into in_ctrl/in_data belongs to the instantiating stage, not this block.

Test Plan:
1. Reset then single push: in_valid=1, in_data=0xA5, out_ready=1 -> out_valid=1 next cycle with out_data=0xA5; then EMPTY, occupancy 0.
2. Backpressure: push 0x1, 0x2, 0x3 with out_ready=0 -> occupancy 1 then 2, in_ready=0 after the second push, 0x3 held upstream. Release out_ready -> outputs 0x1, 0x2, 0x3 in order with no loss.
3. Streaming: in_valid=out_ready=1 for 100 cycles -> one output per cycle, occupancy stays 1, in_ready stays 1.
4. Flush in FULL with a simultaneous Accept -> next cycle out_valid=0, out_ctrl=CTRL_RST, occupancy 0, in_ready=1; the flushed input never appears.
5. Async reset mid-stream (nRST low between edges) -> outputs return to reset values immediately; a subsequent push of 0x7 emerges correctly.
6. With PL_STAGE_PERF_EN: 5 stall cycles and 2 flushes -> stall_cycles=5, flush_count=2. With CNT_W=4 and 20 stalls -> stall_cycles=15 (saturated).

Source files
------------

// File: rtl/pl_stage_pkg.sv
// Shared types and defaults for the elastic pipeline stage register.
package pl_stage_pkg;

  // State encoding doubles as the occupancy count (0/1/2).
  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_HALF  = 2'd1,
    PS_FULL  = 2'd2
  } pl_state_t;

  // Replicated across CTRL_W to form the default NOP bubble control word.
  localparam logic PL_CTRL_RST_BIT = 1'b0;

endpackage

// File: rtl/pl_stage_perf.sv
// Saturating performance counters for pl_stage_elastic (stall cycles, flush cycles).
// Cleared only by nRST; flush has no effect on the counts.
module pl_stage_perf #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             stall_evt,
  input  logic             flush_evt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [CNT_W-1:0] stall_q, flush_q;

  // Count events, holding at all-ones once saturated.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + CntOne;
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + CntOne;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: rtl/pl_stage_elastic.sv
// Generic elastic pipeline stage: valid/ready handshake with a 2-entry skid buffer.
// in_ready is registered so upstream never sees a combinational path from out_ready.
// Optional feature macro: PL_STAGE_PERF_EN adds stall_cycles / flush_count outputs.
module pl_stage_elastic
  import pl_stage_pkg::*;
#(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 128,
`ifdef PL_STAGE_PERF_EN
  parameter int unsigned CNT_W  = 16,
`endif
  parameter logic [CTRL_W-1:0] CTRL_RST = {CTRL_W{PL_CTRL_RST_BIT}}
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
`ifdef PL_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count,
`endif
  output logic [1:0]        occupancy
);

  pl_state_t         state_q, state_d;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              accept, emit;

  assign out_valid = (state_q != PS_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;

  // Next-state and entry movement; main always holds the head entry.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      PS_EMPTY: begin
        if (accept) begin
          state_d     = PS_HALF;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end
      end
      PS_HALF: begin
        if (accept && emit) begin
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (accept) begin
          state_d     = PS_FULL;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else if (emit) begin
          state_d = PS_EMPTY;
        end
      end
      PS_FULL: begin
        // in_ready is low here, so no accept can coincide with the drain.
        if (emit) begin
          state_d     = PS_HALF;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
        end
      end
      default: state_d = PS_EMPTY;
    endcase
    // Flush wins: drop every held entry and discard any same-cycle input.
    if (flush) begin
      state_d     = PS_EMPTY;
      main_ctrl_d = main_ctrl_q;
      main_data_d = main_data_q;
      skid_ctrl_d = skid_ctrl_q;
      skid_data_d = skid_data_q;
    end
  end

  // State, ready flop and entry storage.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= PS_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= CTRL_RST;
      main_data_q <= '0;
      skid_ctrl_q <= CTRL_RST;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != PS_FULL);
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Output view: bubble control when empty, payload holds its last value.
  always_comb begin
    in_ready = in_ready_q;
    out_ctrl = out_valid ? main_ctrl_q : CTRL_RST;
    out_data = main_data_q;
    case (state_q)
      PS_HALF: occupancy = 2'd1;
      PS_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

`ifdef PL_STAGE_PERF_EN
  pl_stage_perf #(
    .CNT_W (CNT_W)
  ) u_perf (
    .CLK          (CLK),
    .nRST         (nRST),
    .stall_evt    (out_valid & ~out_ready),
    .flush_evt    (flush),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`endif

endmodule

// File: tb/tb_pl_stage_elastic.sv
// Self-checking bench for pl_stage_elastic: directed table, hand sequences, random vs queue model.
// Counter checks run only when PL_STAGE_PERF_EN is defined.
module tb_pl_stage_elastic;

  localparam int CW = 16;
  localparam int DW = 128;

  logic          CLK = 1'b0;
  logic          nRST, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic          in_ready, out_valid;
  logic [1:0]    occupancy;
`ifdef PL_STAGE_PERF_EN
  logic [15:0]   stall_cycles, flush_count;
  logic          d4_in_ready, d4_out_valid;
  logic [CW-1:0] d4_out_ctrl;
  logic [DW-1:0] d4_out_data;
  logic [1:0]    d4_occupancy;
  logic [3:0]    d4_stall_cycles, d4_flush_count;
`endif

  always #5 CLK = ~CLK;

  pl_stage_elastic #(
    .CTRL_W (CW),
    .DATA_W (DW)
  ) u_dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (out_ctrl),
    .out_data     (out_data),
`ifdef PL_STAGE_PERF_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .occupancy    (occupancy)
  );

`ifdef PL_STAGE_PERF_EN
  pl_stage_elastic #(
    .CTRL_W (CW),
    .DATA_W (DW),
    .CNT_W  (4)
  ) u_dut4 (
    .CLK          (CLK),
    .nRST         (nRST),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (d4_in_ready),
    .in_ctrl      (in_ctrl),
    .in_data      (in_data),
    .out_valid    (d4_out_valid),
    .out_ready    (out_ready),
    .out_ctrl     (d4_out_ctrl),
    .out_data     (d4_out_data),
    .stall_cycles (d4_stall_cycles),
    .flush_count  (d4_flush_count),
    .occupancy    (d4_occupancy)
  );
`endif

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a FIFO of at most two entries plus the last head payload seen.
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic [DW-1:0] m_last;

  function automatic void model_step();
    bit e, a;
    e = (mq.size() > 0) && out_ready;
    a = in_valid && (mq.size() < 2);
    if (flush) begin
      mq.delete();
    end else begin
      if (e) void'(mq.pop_front());
      if (a) mq.push_back('{c: in_ctrl, d: in_data});
    end
    if (mq.size() > 0) m_last = mq[0].d;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(mq.size() > 0));
    chk({tag, ".out_ctrl"},  128'(out_ctrl),  (mq.size() > 0) ? 128'(mq[0].c) : 128'(0));
    chk({tag, ".out_data"},  out_data,        m_last);
    chk({tag, ".in_ready"},  128'(in_ready),  128'(mq.size() < 2));
    chk({tag, ".occupancy"}, 128'(occupancy), 128'(mq.size()));
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic reset_dut();
    nRST      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    mq.delete();
    m_last    = '0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic          fl, iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          ev;
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    logic          er;
    logic [1:0]    eo;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // fl iv ctrl data ordy | exp: valid ctrl data in_ready occupancy
    tbl[0]  = '{1'b0, 1'b1, 16'h11, 128'hA5, 1'b1, 1'b1, 16'h11, 128'hA5, 1'b1, 2'd1};
    tbl[1]  = '{1'b0, 1'b0, 16'h00, 128'h0,  1'b1, 1'b0, 16'h00, 128'hA5, 1'b1, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, 16'h21, 128'h1,  1'b0, 1'b1, 16'h21, 128'h1,  1'b1, 2'd1};
    tbl[3]  = '{1'b0, 1'b1, 16'h22, 128'h2,  1'b0, 1'b1, 16'h21, 128'h1,  1'b0, 2'd2};
    tbl[4]  = '{1'b0, 1'b1, 16'h23, 128'h3,  1'b0, 1'b1, 16'h21, 128'h1,  1'b0, 2'd2};
    tbl[5]  = '{1'b0, 1'b1, 16'h23, 128'h3,  1'b1, 1'b1, 16'h22, 128'h2,  1'b1, 2'd1};
    tbl[6]  = '{1'b0, 1'b1, 16'h23, 128'h3,  1'b1, 1'b1, 16'h23, 128'h3,  1'b1, 2'd1};
    tbl[7]  = '{1'b0, 1'b0, 16'h00, 128'h0,  1'b1, 1'b0, 16'h00, 128'h3,  1'b1, 2'd0};
    tbl[8]  = '{1'b0, 1'b1, 16'h24, 128'h4,  1'b0, 1'b1, 16'h24, 128'h4,  1'b1, 2'd1};
    tbl[9]  = '{1'b0, 1'b1, 16'h25, 128'h5,  1'b0, 1'b1, 16'h24, 128'h4,  1'b0, 2'd2};
    tbl[10] = '{1'b1, 1'b1, 16'h26, 128'h6,  1'b0, 1'b0, 16'h00, 128'h4,  1'b1, 2'd0};
    tbl[11] = '{1'b0, 1'b1, 16'h27, 128'h7,  1'b0, 1'b1, 16'h27, 128'h7,  1'b1, 2'd1};
    tbl[12] = '{1'b1, 1'b1, 16'h28, 128'h8,  1'b1, 1'b0, 16'h00, 128'h7,  1'b1, 2'd0};
    tbl[13] = '{1'b0, 1'b0, 16'h00, 128'h0,  1'b1, 1'b0, 16'h00, 128'h7,  1'b1, 2'd0};

    reset_dut();
    chk("rst.out_valid", 128'(out_valid), 128'(0));
    chk("rst.out_ctrl",  128'(out_ctrl),  128'(0));
    chk("rst.out_data",  out_data,        128'(0));
    chk("rst.in_ready",  128'(in_ready),  128'(1));
    chk("rst.occupancy", 128'(occupancy), 128'(0));

    // Directed table: single push, backpressure, flush in FULL and in HALF.
    for (int i = 0; i < 14; i++) begin
      flush     = tbl[i].fl;
      in_valid  = tbl[i].iv;
      in_ctrl   = tbl[i].ic;
      in_data   = tbl[i].id;
      out_ready = tbl[i].ordy;
      cycle();
      chk($sformatf("vec%0d.out_valid", i), 128'(out_valid), 128'(tbl[i].ev));
      chk($sformatf("vec%0d.out_ctrl", i),  128'(out_ctrl),  128'(tbl[i].ec));
      chk($sformatf("vec%0d.out_data", i),  out_data,        tbl[i].ed);
      chk($sformatf("vec%0d.in_ready", i),  128'(in_ready),  128'(tbl[i].er));
      chk($sformatf("vec%0d.occupancy", i), 128'(occupancy), 128'(tbl[i].eo));
    end
    flush = 1'b0;

    // Streaming: one result per cycle, occupancy steady at one.
    for (int i = 0; i < 100; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_ctrl   = CW'(16'h100 + i);
      in_data   = DW'(1000 + i);
      cycle();
      chk($sformatf("stream%0d.out_valid", i), 128'(out_valid), 128'(1));
      chk($sformatf("stream%0d.out_data", i),  out_data,        128'(1000 + i));
      chk($sformatf("stream%0d.occupancy", i), 128'(occupancy), 128'(1));
      chk($sformatf("stream%0d.in_ready", i),  128'(in_ready),  128'(1));
    end
    in_valid = 1'b0;
    cycle();
    check_model("stream_end");

    // Async reset while FULL, asserted and released between clock edges.
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_ctrl   = 16'h31;
    in_data   = 128'h9;
    cycle();
    in_ctrl = 16'h32;
    in_data = 128'hA;
    cycle();
    chk("arst.pre_occupancy", 128'(occupancy), 128'(2));
    in_valid = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    chk("arst.out_valid", 128'(out_valid), 128'(0));
    chk("arst.out_ctrl",  128'(out_ctrl),  128'(0));
    chk("arst.out_data",  out_data,        128'(0));
    chk("arst.in_ready",  128'(in_ready),  128'(1));
    chk("arst.occupancy", 128'(occupancy), 128'(0));
    mq.delete();
    m_last = '0;
    @(negedge CLK);
    nRST      = 1'b1;
    in_valid  = 1'b1;
    in_ctrl   = 16'h37;
    in_data   = 128'h7;
    out_ready = 1'b1;
    cycle();
    chk("arst.push_data",  out_data,        128'h7);
    chk("arst.push_valid", 128'(out_valid), 128'(1));
    check_model("arst.push");
    in_valid = 1'b0;
    cycle();
    check_model("arst.drain");

    // Random traffic against the queue model.
    for (int i = 0; i < 3000; i++) begin
      flush     = ($urandom_range(15) == 0);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(1) == 1);
      in_ctrl   = CW'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      check_model($sformatf("rnd%0d", i));
    end
    flush    = 1'b0;
    in_valid = 1'b0;

`ifdef PL_STAGE_PERF_EN
    // Five stall cycles and two flush cycles.
    reset_dut();
    in_valid = 1'b1;
    in_data  = 128'h55;
    in_ctrl  = 16'h55;
    cycle();
    in_valid = 1'b0;
    repeat (5) cycle();
    out_ready = 1'b1;
    cycle();
    flush = 1'b1;
    cycle();
    cycle();
    flush = 1'b0;
    chk("perf.stall5", 128'(stall_cycles), 128'(5));
    chk("perf.flush2", 128'(flush_count),  128'(2));
    // Twenty stalls saturate the 4-bit counter at 15.
    reset_dut();
    chk("perf.rst_stall", 128'(stall_cycles), 128'(0));
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    chk("perf.stall20",    128'(stall_cycles),    128'(20));
    chk("perf.stall_sat4", 128'(d4_stall_cycles), 128'(15));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
